dmem_responder: RTL and testbench

- Multi-cycle data-memory target that services the pipeline's MEM-stage load/store requests through a req/ack handshake.
- Holds a word-addressed storage array and models configurable access latency.
- Raises a stall so the pipeline freezes IF/ID/EX/MEM until the access completes.
- Flags misaligned and out-of-range accesses.

---
 rtl/dmem_responder.sv | 73 +++++++
 tb/tb_dmem_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory target with req/ack handshake,
// stall generation for the pipeline, and rejection of misaligned or out-of-range accesses.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, nxt;
    logic [3:0]              cnt;
    logic                    lat_we;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic [31:0]             lat_wdata;
    logic                    valid, take, fire;
    logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

    always_comb begin
        valid   = (addr_i[1:0] == 2'b00) && (addr_i[31:DEPTH_LOG2+2] == '0);
        take    = (state == IDLE) && req_i && valid;
        fire    = (state == BUSY) && (cnt == 4'd0);
        stall_o = take || (state == BUSY);
        nxt     = state;
        case (state)
            IDLE:    nxt = take ? BUSY : IDLE;
            BUSY:    nxt = fire ? DONE : BUSY;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= 32'd0;
        end else begin
            state <= nxt;
            ack_o <= fire;
            err_o <= (state == IDLE) && req_i && !valid;
            if (take) begin
                lat_we    <= we_i;
                lat_idx   <= addr_i[DEPTH_LOG2+1:2];
                lat_wdata <= wdata_i;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !lat_we)
                rdata_o <= mem[lat_idx];
        end
    end

    // The array has no reset; an aborted access never reaches fire because reset forces IDLE.
    always_ff @(posedge clk_i) begin
        if (fire && lat_we)
            mem[lat_idx] <= lat_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=4 and LATENCY=1.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req4 = 1'b0, req1 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        ack4, stall4, err4, ack1, stall1, err1;
    logic [31:0] rdata4, rdata1;
    int          n_tests = 0, n_fail = 0;
    int          stalls, ack_at, acks, err_at, errs;
    logic [31:0] rd;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req4), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack4), .rdata_o(rdata4), .stall_o(stall4), .err_o(err4)
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack1), .rdata_o(rdata1), .stall_o(stall1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Cycle 1 is the request cycle; later cycles are observed 1ns after each rising edge.
    task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit scr, output int st, output int aat, output int na,
                          output int eat, output int ne, output logic [31:0] r);
        st = 0; aat = 0; na = 0; eat = 0; ne = 0; r = 32'd0;
        @(negedge clk);
        we = w; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req4 = 1'b1;
        #1;
        st += int'(sel ? stall1 : stall4);
        @(posedge clk); #1;
        if (!scr) begin req1 = 1'b0; req4 = 1'b0; end
        for (int i = 2; i <= 12; i++) begin
            if (sel ? stall1 : stall4) st++;
            if ((sel ? ack1 : ack4) && aat == 0) begin
                aat = i;
                r = sel ? rdata1 : rdata4;
            end
            if ((sel ? err1 : err4) && eat == 0) eat = i;
            na += int'(sel ? ack1 : ack4);
            ne += int'(sel ? err1 : err4);
            if (scr && i == 2) begin addr = 32'h10; we = 1'b1; wdata = 32'hFFFF_FFFF; end
            if (scr && i == 4) req4 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2;
        check("rst_ack", 32'(ack4), 0);
        check("rst_err", 32'(err4), 0);
        check("rst_stall", 32'(stall4), 0);
        check("rst_rdata", rdata4, 0);
        @(negedge clk); rst_i = 1'b1;

        access(0, 1, 32'h10, 32'hDEAD_BEEF, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("st10_stall_cycles", 32'(stalls), 5);
        check("st10_ack_cycle", 32'(ack_at), 6);
        check("st10_ack_count", 32'(acks), 1);
        check("st10_err_count", 32'(errs), 0);

        access(0, 0, 32'h10, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("ld10_data", rd, 32'hDEAD_BEEF);
        check("ld10_ack_cycle", 32'(ack_at), 6);
        check("ld10_hold", rdata4, 32'hDEAD_BEEF);

        access(0, 1, 32'h14, 32'h0BAD_F00D, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("st14_ack_count", 32'(acks), 1);
        check("st14_rdata_kept", rdata4, 32'hDEAD_BEEF);

        access(0, 0, 32'h12, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("mis_err_cycle", 32'(err_at), 2);
        check("mis_err_count", 32'(errs), 1);
        check("mis_stall", 32'(stalls), 0);
        check("mis_ack_count", 32'(acks), 0);

        access(0, 1, 32'h0, 32'h55AA_55AA, 0, stalls, ack_at, acks, err_at, errs, rd);
        access(0, 1, 32'h1000, 32'h9999_9999, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("oor_err_count", 32'(errs), 1);
        check("oor_ack_count", 32'(acks), 0);
        check("oor_stall", 32'(stalls), 0);
        access(0, 0, 32'h0, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("oor_word0_kept", rd, 32'h55AA_55AA);

        access(0, 1, 32'h20, 32'hCAFE_F00D, 0, stalls, ack_at, acks, err_at, errs, rd);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; req4 = 1'b1;
        @(posedge clk); #1; req4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_i = 1'b0; #1;
        check("abort_stall", 32'(stall4), 0);
        check("abort_ack", 32'(ack4), 0);
        check("abort_rdata", rdata4, 0);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_i = 1'b1;
            @(negedge clk);
            acks += int'(ack4);
        end
        check("abort_no_ack", 32'(acks), 0);
        access(0, 0, 32'h20, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("abort_old_value", rd, 32'hCAFE_F00D);

        access(0, 1, 32'h4, 32'h1111_2222, 0, stalls, ack_at, acks, err_at, errs, rd);
        access(0, 0, 32'h4, 32'h0, 1, stalls, ack_at, acks, err_at, errs, rd);
        check("busy_chg_data", rd, 32'h1111_2222);
        check("busy_chg_ack_count", 32'(acks), 1);
        access(0, 0, 32'h10, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("busy_chg_no_write", rd, 32'hDEAD_BEEF);

        access(1, 1, 32'hFFC, 32'hA5A5_A5A5, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("l1_st_ack_cycle", 32'(ack_at), 3);
        check("l1_st_stall_cycles", 32'(stalls), 2);
        access(1, 0, 32'hFFC, 32'h0, 0, stalls, ack_at, acks, err_at, errs, rd);
        check("l1_ld_ack_cycle", 32'(ack_at), 3);
        check("l1_ld_data", rd, 32'hA5A5_A5A5);
        check("l1_ld_ack_count", 32'(acks), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
